// File: rtl/tail_light_input_cond_pkg.sv
// Shared constants for the tail-light input conditioner: default counts for
// simulation and board builds, and the switch channel indices.
package tail_light_pkg;

  localparam int DEF_SYNC_STAGES       = 2;
  localparam int SIM_DEBOUNCE_CYCLES   = 20;
  localparam int BOARD_DEBOUNCE_CYCLES = 1_000_000;
  localparam int SIM_STEP_CYCLES       = 50;
  localparam int BOARD_STEP_CYCLES     = 12_500_000;

  localparam int NUM_CH    = 4;
  localparam int CH_LEFT   = 0;
  localparam int CH_RIGHT  = 1;
  localparam int CH_HAZARD = 2;
  localparam int CH_BRAKE  = 3;

  typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage

// File: rtl/tail_light_input_cond_if.sv
// Raw board switches in, conditioned sequencer requests and step strobe out.
interface tail_light_input_cond_if;
  logic sw_left;
  logic sw_right;
  logic sw_hazard;
  logic sw_brake;
  logic left;
  logic right;
  logic hazard;
  logic brake;
  logic step;

  modport master (
    output sw_left, sw_right, sw_hazard, sw_brake,
    input  left, right, hazard, brake, step
  );

  modport slave (
    input  sw_left, sw_right, sw_hazard, sw_brake,
    output left, right, hazard, brake, step
  );
endinterface

// File: rtl/tail_light_input_cond_switch_debounce.sv
// One switch channel: SYNC_STAGES-deep synchroniser followed by a counter
// that accepts a new level only after DEBOUNCE_CYCLES consecutive differing cycles.
module switch_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   sync_x;

  assign sync_x = sync_q[SYNC_STAGES-1];

  // Any cycle that agrees with the stable level restarts the count.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw};
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_x != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stable_d = sync_x;
      else                                   cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/tail_light_input_cond.sv
// Conditions four raw switches into step-aligned level requests for the
// tail-light sequencer, with optional push-to-toggle hazard and a slow step strobe.
module tail_light_input_cond
  import tail_light_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE_CYCLES,
  parameter int STEP_CYCLES     = SIM_STEP_CYCLES,
  parameter int HAZARD_LATCH    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  tail_light_input_cond_if.slave  io
);

  localparam int SW = $clog2(STEP_CYCLES);

  ch_vec_t        raw_vec;
  ch_vec_t        stable_vec;
  logic           haz_lvl;
  logic           step;
  logic [SW-1:0]  step_cnt_q, step_cnt_d;
  ch_vec_t        out_q, out_d;

  assign raw_vec[CH_LEFT]   = io.sw_left;
  assign raw_vec[CH_RIGHT]  = io.sw_right;
  assign raw_vec[CH_HAZARD] = io.sw_hazard;
  assign raw_vec[CH_BRAKE]  = io.sw_brake;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    switch_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .raw    (raw_vec[g]),
      .stable (stable_vec[g])
    );
  end

  if (HAZARD_LATCH != 0) begin : g_haz_latch
    logic haz_prev_q, haz_prev_d;
    logic haz_lvl_q, haz_lvl_d;

    // Only the press edge toggles; release is ignored.
    always_comb begin
      haz_prev_d = stable_vec[CH_HAZARD];
      haz_lvl_d  = haz_lvl_q ^ (stable_vec[CH_HAZARD] & ~haz_prev_q);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        haz_prev_q <= 1'b0;
        haz_lvl_q  <= 1'b0;
      end else begin
        haz_prev_q <= haz_prev_d;
        haz_lvl_q  <= haz_lvl_d;
      end
    end

    assign haz_lvl = haz_lvl_q;
  end else begin : g_haz_level
    assign haz_lvl = stable_vec[CH_HAZARD];
  end

  assign step = (step_cnt_q == SW'(STEP_CYCLES - 1));

  // Outputs sample the pre-edge stable levels only at the end of a step cycle.
  always_comb begin
    step_cnt_d = step ? '0 : step_cnt_q + 1'b1;
    out_d      = out_q;
    if (step) begin
      out_d            = stable_vec;
      out_d[CH_HAZARD] = haz_lvl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt_q <= '0;
      out_q      <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
      out_q      <= out_d;
    end
  end

  assign io.left   = out_q[CH_LEFT];
  assign io.right  = out_q[CH_RIGHT];
  assign io.hazard = out_q[CH_HAZARD];
  assign io.brake  = out_q[CH_BRAKE];
  assign io.step   = step;

endmodule

// File: tb/tb_tail_light_input_cond.sv
// Drives two conditioners (latched and level hazard) with shared switch
// stimulus and compares every cycle against a history-based reference model.
module tb_tail_light_input_cond;
  import tail_light_pkg::*;

  localparam int SS = 2;
  localparam int DB = 20;
  localparam int ST = 50;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tail_light_input_cond_if io_l();
  tail_light_input_cond_if io_v();

  tail_light_input_cond #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .STEP_CYCLES(ST), .HAZARD_LATCH(1))
    u_dut_latch (.clk(clk), .reset(reset), .io(io_l));
  tail_light_input_cond #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .STEP_CYCLES(ST), .HAZARD_LATCH(0))
    u_dut_level (.clk(clk), .reset(reset), .io(io_v));

  int checks   = 0;
  int failures = 0;

  // Reference model: cycle index since reset release, raw history since then.
  int         t;
  logic [3:0] raw_hist[$];
  logic [3:0] m_stable;
  logic [3:0] m_out_l, m_out_v;
  logic       m_haz_lvl, m_haz_prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  function automatic logic sync_at(input int ch, input int k);
    logic [3:0] r;
    if (k < SS) return 1'b0;
    r = raw_hist[k-SS];
    return r[ch];
  endfunction

  task automatic model_clear();
    t          = 0;
    raw_hist.delete();
    m_stable   = '0;
    m_out_l    = '0;
    m_out_v    = '0;
    m_haz_lvl  = 1'b0;
    m_haz_prev = 1'b0;
  endtask

  // A level is accepted once the synchronised input has shown it, different
  // from the current level, for the last DB cycles.
  task automatic model_advance(input logic rst);
    logic [3:0] nxt;
    logic       v, same;
    if (rst) begin
      model_clear();
      return;
    end
    if (t % ST == ST - 1) begin
      m_out_l            = m_stable;
      m_out_l[CH_HAZARD] = m_haz_lvl;
      m_out_v            = m_stable;
    end
    nxt = m_stable;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (t >= DB - 1) begin
        v    = sync_at(ch, t);
        same = 1'b1;
        for (int k = t - DB + 1; k <= t; k++)
          if (sync_at(ch, k) != v) same = 1'b0;
        if (same && v != m_stable[ch]) nxt[ch] = v;
      end
    end
    if (m_stable[CH_HAZARD] && !m_haz_prev) m_haz_lvl = ~m_haz_lvl;
    m_haz_prev = m_stable[CH_HAZARD];
    m_stable   = nxt;
    t++;
  endtask

  task automatic drive(input logic [3:0] sw);
    io_l.sw_left  = sw[CH_LEFT];   io_v.sw_left  = sw[CH_LEFT];
    io_l.sw_right = sw[CH_RIGHT];  io_v.sw_right = sw[CH_RIGHT];
    io_l.sw_hazard= sw[CH_HAZARD]; io_v.sw_hazard= sw[CH_HAZARD];
    io_l.sw_brake = sw[CH_BRAKE];  io_v.sw_brake = sw[CH_BRAKE];
  endtask

  // Entered just after a rising edge; applies one cycle of stimulus.
  task automatic cycle(input logic [3:0] sw, input logic rst);
    reset = rst;
    drive(sw);
    if (!rst) raw_hist.push_back(sw);
    @(negedge clk);
    chk("step_l",   32'(io_l.step),   32'(t % ST == ST - 1));
    chk("step_v",   32'(io_v.step),   32'(t % ST == ST - 1));
    chk("left_l",   32'(io_l.left),   32'(m_out_l[CH_LEFT]));
    chk("right_l",  32'(io_l.right),  32'(m_out_l[CH_RIGHT]));
    chk("brake_l",  32'(io_l.brake),  32'(m_out_l[CH_BRAKE]));
    chk("hazard_l", 32'(io_l.hazard), 32'(m_out_l[CH_HAZARD]));
    chk("left_v",   32'(io_v.left),   32'(m_out_v[CH_LEFT]));
    chk("right_v",  32'(io_v.right),  32'(m_out_v[CH_RIGHT]));
    chk("brake_v",  32'(io_v.brake),  32'(m_out_v[CH_BRAKE]));
    chk("hazard_v", 32'(io_v.hazard), 32'(m_out_v[CH_HAZARD]));
    @(posedge clk);
    model_advance(rst);
    #1;
  endtask

  initial begin
    logic [3:0] sw;
    int         hold[4];

    reset = 1'b1;
    drive(4'b0000);
    repeat (3) @(posedge clk);
    #1;
    model_clear();

    // Idle: step pulses only at 49, 99, 149.
    for (int i = 0; i < 160; i++) cycle(4'b0000, 1'b0);

    // Left held then released, two hazard presses, short brake glitch.
    cycle(4'b0000, 1'b1);
    for (int i = 0; i < 220; i++) begin
      sw            = '0;
      sw[CH_LEFT]   = (i < 60);
      sw[CH_HAZARD] = (i < 30) || (i >= 60 && i < 90);
      sw[CH_BRAKE]  = (i >= 5 && i < 15);
      cycle(sw, 1'b0);
    end
    chk("left_dir",   32'(io_l.left),   32'd0);
    chk("hazard_dir", 32'(io_l.hazard), 32'd0);

    // Right held with a reset partway through its debounce.
    cycle(4'b0000, 1'b1);
    for (int i = 0; i < 15; i++) cycle(4'b0010, 1'b0);
    cycle(4'b0010, 1'b1);
    for (int i = 0; i < 120; i++) cycle(4'b0010, 1'b0);
    chk("right_dir", 32'(io_l.right), 32'd1);

    // Random holds mixing sub- and super-debounce lengths, occasional resets.
    sw = '0;
    for (int ch = 0; ch < 4; ch++) hold[ch] = $urandom_range(1, 60);
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < 4; ch++) begin
        hold[ch]--;
        if (hold[ch] <= 0) begin
          sw[ch]   = ~sw[ch];
          hold[ch] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DB - 1)
                                                  : $urandom_range(DB, 120);
        end
      end
      cycle(sw, ($urandom_range(0, 499) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
